cdc_handshake_tx: RTL
=====================

Name: cdc_handshake_tx

Overview:
- Source-side half of a two-phase (toggle) bundled-data clock-domain-crossing handshake.
- Accepts multi-bit words through a valid/ready interface in its own clock domain.
- Holds each word stable on the crossing bus and toggles a request line.
- Releases the next word only after the destination's toggled acknowledge has been synchronized back into this domain; the matching receiver lives in the destination domain.

Parameters:
- DATA_WIDTH, 32, width of the transferred word.
- SYNC_DEPTH, 2, flop stages on the incoming ack synchronizer; legal values are 2 and above.

Ports:
- clk  input  1  source-domain clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_WIDTH  upstream word.
- req_o  output  1  toggle request to the destination domain; registered.
- data_o  output  DATA_WIDTH  crossing data bus; registered, stable while a transfer is outstanding.
- ack_i  input  1  toggle acknowledge from the destination domain; asynchronous to clk.
- busy  output  1  transfer outstanding.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, req_o=0, data_o=0, proto_err=0, ack synchronizer stages all 0. Consequently in_ready=1 and busy=0 after reset.
- ack_s: ack_i passed through a SYNC_DEPTH-deep flop chain; ack_s is the last stage.
- State machine, two states:
  - IDLE: in_ready=1, busy=0. When in_valid is high, the word is accepted on the clock edge: data_o<=in_data, req_o<=~req_o, next state WAIT_ACK.
  - WAIT_ACK: in_ready=0, busy=1, and data_o and req_o hold. When ack_s==req_o, next state is IDLE, so in_ready rises in the following cycle.
- Latency:
  - req_o toggles and data_o updates in the cycle after acceptance.
  - Minimum source-side round trip, from acceptance to the next in_ready=1, is SYNC_DEPTH + destination response + 1 cycles.
  - No back-to-back acceptance is possible; one word is in flight at a time.
- Bundled-data rule: data_o must not change while req_o != ack_s. The destination samples data only after it has synchronized the req edge.
- in_ready does not depend combinationally on in_valid; it is a pure function of the state.
- in_valid is ignored in WAIT_ACK. Upstream keeps holding the word until in_ready=1.
- Protocol errors:
  - Error condition: in IDLE, ack_s != req_o, meaning ack toggled with no request outstanding.
  - On the clock edge where this is detected, proto_err is set to 1. It stays set until rst.
  - The state machine ignores the spurious edge.
- Simultaneous events:
  - A WAIT_ACK→IDLE transition and in_valid=1 in the same cycle: the word is not accepted, because in_ready is still 0 in that cycle.
  - Acceptance happens at the earliest in the next cycle.
- Reset mid-transfer: asserting rst in WAIT_ACK forces IDLE, req_o=0 and data_o=0 asynchronously, and the transfer is abandoned. The destination domain must be reset in the same event, otherwise proto_err can set after reset release.
- Wrap-around: req_o/ack parity simply alternates, with no counter overflow concern.

Decomposition:
- Shared package cdc_pkg:
  - typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_e.
  - Constant CDC_MIN_SYNC_DEPTH = 2. Also used by the matching receiver and checked with an elaboration-time assertion on SYNC_DEPTH.
- One sub-module: the existing synchronizer_ff, instantiated with DATA_WIDTH=1 and SYNC_DEPTH=SYNC_DEPTH on ack_i.
- Everything else (FSM, data/req registers, error flag) stays in cdc_handshake_tx.

Test Plan:
- Reset release, no stimulus, ack_i=0 → in_ready=1, busy=0, req_o=0, data_o=0, proto_err=0 indefinitely.
- Single transfer: in_valid=1, in_data=32'hDEADBEEF for one cycle, with an ack model that toggles ack_i 3 cycles after the req_o edge →
  - data_o=32'hDEADBEEF and req_o=1 one cycle after acceptance.
  - busy=1 until ack_s matches.
  - in_ready returns high exactly SYNC_DEPTH+1 cycles after the ack_i edge.
- Back-to-back words 32'h1, 32'h2, 32'h3 with in_valid held high → three req_o toggles (1,0,1). Each data_o value is held unchanged for the whole of its WAIT_ACK period, with no acceptance while in_ready=0.
- Spurious ack: toggle ack_i while IDLE → proto_err=1 after SYNC_DEPTH+1 cycles and stays 1; the FSM stays IDLE and in_ready stays 1.
- Reset mid-transfer: accept 32'hA5A5A5A5, then assert rst before the ack returns → req_o=0, data_o=0 and in_ready=1 immediately (asynchronously). With the destination model also reset, a new transfer completes normally.
- SYNC_DEPTH=4 build: repeat the single-transfer scenario → the ack-to-in_ready latency grows to 5 cycles.

Source files
------------

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the toggle-handshake CDC pair
package cdc_pkg;

    // Source-side handshake states
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_tx_state_e;

    // Fewer stages than this leaves too little metastability settling time
    localparam int CDC_MIN_SYNC_DEPTH = 2;

    // A two-phase transfer is outstanding whenever the parities differ
    function automatic logic toggle_pending(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/synchronizer_ff.sv
// rtl/synchronizer_ff.sv - multi-stage flop synchronizer for level signals
module synchronizer_ff #(
    parameter int DATA_WIDTH = 1,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] stages [SYNC_DEPTH];

    // Shift the asynchronous input through the settling chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source half of a two-phase bundled-data CDC handshake
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [0:0] ST_IDLE     = IDLE;
    localparam logic [0:0] ST_WAIT_ACK = WAIT_ACK;

    if (SYNC_DEPTH < CDC_MIN_SYNC_DEPTH) begin : g_bad_sync_depth
        $error("cdc_handshake_tx: SYNC_DEPTH below CDC_MIN_SYNC_DEPTH");
    end

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       ack_s;
    logic       accept;
    logic       spurious_ack;

    synchronizer_ff #(
        .DATA_WIDTH (1),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_i),
        .q   (ack_s)
    );

    // Readiness depends only on state so upstream never sees a comb loop
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_WAIT_ACK);
    assign accept   = in_ready && in_valid;

    // An ack edge arriving while nothing is outstanding is a far-side fault
    assign spurious_ack = in_ready && toggle_pending(req_o, ack_s);

    // Next-state: leave WAIT_ACK once the synchronized ack parity catches up
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!toggle_pending(req_o, ack_s)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the word and flip request parity only on acceptance, so the
    // bus is frozen for the whole time the destination may be sampling it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o <= '0;
            req_o  <= 1'b0;
        end else if (accept) begin
            data_o <= in_data;
            req_o  <= ~req_o;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (spurious_ack) begin
            proto_err <= 1'b1;
        end
    end

endmodule
